// File: rtl/riscky_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, controller states and the
// encodings used on the datapath select/control lines.
package riscky_pkg;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWrite, StMemWb,
      StExecR, StExecI, StAluWb, StJal, StBeq, StTrap
   } state_e;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARd1   = 2'b10;

   localparam logic [1:0] SrcBRd2  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ImmI = 2'b00;
   localparam logic [1:0] ImmS = 2'b01;
   localparam logic [1:0] ImmB = 2'b10;
   localparam logic [1:0] ImmJ = 2'b11;

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OpStore:  return ImmS;
         OpBranch: return ImmB;
         OpJal:    return ImmJ;
         default:  return ImmI;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus instruction fields onto the ALU control code.
module multicycle_controller_alu_decoder
   import riscky_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [2:0] alu_control
);

   // Only op[5] (R vs I) and funct7[5] (sub) matter here.
   logic unused_fields;
   assign unused_fields = ^{op[6], op[4:0], funct7[6], funct7[4:0]};

   always_comb begin
      alu_control = AluAdd;
      case (alu_op)
         AluOpSub: alu_control = AluSub;
         AluOpFunct: begin
            case (funct3)
               3'b000:  alu_control = (op[5] & funct7[5]) ? AluSub : AluAdd;
               3'b010:  alu_control = AluSlt;
               3'b110:  alu_control = AluOr;
               3'b111:  alu_control = AluAnd;
               default: alu_control = AluAdd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: per-state datapath enables/selects, stalls on the
// shared memory via mem_ready, and parks in a sticky trap on unsupported opcodes.
module multicycle_controller
   import riscky_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   state_e     state_q, state_d;
   logic       illegal_q;
   logic       pc_update, branch;
   logic [1:0] alu_op;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == StTrap) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = ResAluOut;
      ALUSrcA   = SrcAPc;
      ALUSrcB   = SrcBRd2;
      alu_op    = AluOpAdd;
      unique case (state_q)
         StFetch: begin
            IRWrite   = mem_ready;
            pc_update = mem_ready;
            ALUSrcA   = SrcAPc;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            // Branch target is computed here and parked in ALUOut.
            ALUSrcA = SrcAOldPc;
            ALUSrcB = SrcBImm;
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRtype:         state_d = StExecR;
               OpItype:         state_d = StExecI;
               OpBranch:        state_d = StBeq;
               OpJal:           state_d = StJal;
               default:         state_d = StTrap;
            endcase
         end
         StMemAdr: begin
            ALUSrcA = SrcARd1;
            ALUSrcB = SrcBImm;
            state_d = (op == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_d = StFetch;
         end
         StMemWb: begin
            ResultSrc = ResData;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StExecR: begin
            ALUSrcA = SrcARd1;
            ALUSrcB = SrcBRd2;
            alu_op  = AluOpFunct;
            state_d = StAluWb;
         end
         StExecI: begin
            ALUSrcA = SrcARd1;
            ALUSrcB = SrcBImm;
            alu_op  = AluOpFunct;
            state_d = StAluWb;
         end
         StAluWb: begin
            RegWrite = 1'b1;
            state_d  = StFetch;
         end
         StJal: begin
            ALUSrcA   = SrcAOldPc;
            ALUSrcB   = SrcBFour;
            pc_update = 1'b1;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StBeq: begin
            ALUSrcA = SrcARd1;
            ALUSrcB = SrcBRd2;
            alu_op  = AluOpSub;
            branch  = 1'b1;
            state_d = StFetch;
         end
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
   end

   multicycle_controller_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .op          (op),
      .funct3      (funct3),
      .funct7      (funct7),
      .alu_control (ALUControl)
   );

   assign PCWrite   = pc_update | (branch & zero);
   assign ImmSrc    = imm_src(op);
   assign illegal   = illegal_q;
   assign state_dbg = STATE_W'(state_q);

endmodule
